// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the N-to-1 streaming multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   ch_idx_w()           : width of a channel index for a given channel count.
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A 2-channel mux still needs one index bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant logic. Searches the request vector
// starting at the pointer and wrapping modulo NUM_CH; the first requester wins.
// The pointer register itself lives in the parent.
//   i_req     : per-channel request
//   i_ptr     : channel with highest priority this cycle
//   o_gnt     : one-hot grant (all zero when nobody requests)
//   o_gnt_idx : index of the granted channel
//   o_gnt_vld : a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_gnt_idx,
    output logic              o_gnt_vld
);

    logic [CH_W-1:0] w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = CH_W'((int'(i_ptr) + k) % NUM_CH);
            if (!o_gnt_vld && i_req[w_idx]) begin
                o_gnt_vld    = 1'b1;
                o_gnt_idx    = w_idx;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// -----------------------------------------------------------------------------
// stream_mux_nto1
// N-channel valid/ready multiplexer with a single-entry registered output.
// Fixed-select mode steers channel 'sel'; round-robin mode arbitrates fairly
// among requesting channels. Every output beat carries its source channel.
//
// Optional feature macro: STREAM_MUX_LOCK_EN
//   When defined, a packet lock holds the grant on one channel from the first
//   accepted beat until the beat with in_last set, and the in_last/out_last
//   ports exist.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   mode         : 0 = fixed select, 1 = round-robin
//   sel          : channel chosen in fixed mode (>= NUM_CH selects nothing)
//   in_data      : channel i at [i*DATA_W +: DATA_W]
//   in_valid     : per-channel valid
//   in_ready     : per-channel ready, at most one bit set
//   in_last      : per-channel end-of-packet (lock build only)
//   out_data     : registered output data
//   out_ch       : source channel of out_data
//   out_valid    : output register holds a beat
//   out_ready    : consumer accepts
//   out_last     : registered in_last of the accepted beat (lock build only)
// -----------------------------------------------------------------------------
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int CH_W   = ch_idx_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [CH_W-1:0]          sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]        in_last,
    output logic                     out_last,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic              r_out_valid;
    logic [CH_W-1:0]   r_rr_ptr;

    logic [DATA_W-1:0] w_ch_data [NUM_CH];
    logic [NUM_CH-1:0] w_arb_oh;
    logic [CH_W-1:0]   w_arb_idx;
    logic              w_arb_vld;
    logic [NUM_CH-1:0] w_gnt_oh;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_gnt_vld;
    logic              w_load;
    logic              w_accept;
    logic              w_pkt_end;
    logic [CH_W-1:0]   w_nxt_ptr;

`ifdef STREAM_MUX_LOCK_EN
    logic              r_lock;
    logic [CH_W-1:0]   r_lock_ch;
    logic              r_out_last;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_CH    (NUM_CH)
    ) u_arb (
        .i_req     (in_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_arb_oh),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_vld (w_arb_vld)
    );

    // The register can take a new beat when empty or draining this cycle.
    assign w_load = ~r_out_valid | out_ready;

    // Grant priority: held packet lock, then the mode's own choice.
    always_comb begin
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
        if (r_lock) begin
            w_gnt_idx           = r_lock_ch;
            w_gnt_vld           = 1'b1;
            w_gnt_oh[r_lock_ch] = 1'b1;
        end else
`endif
        if (mode == MODE_RR) begin
            w_gnt_oh  = w_arb_oh;
            w_gnt_idx = w_arb_idx;
            w_gnt_vld = w_arb_vld;
        end else if (int'(sel) < NUM_CH) begin
            // Fixed mode offers ready to 'sel' whether or not it is valid.
            w_gnt_idx     = sel;
            w_gnt_vld     = 1'b1;
            w_gnt_oh[sel] = 1'b1;
        end
    end

    assign in_ready = (rst_n && w_load) ? w_gnt_oh : '0;
    assign w_accept = w_gnt_vld & in_valid[w_gnt_idx] & w_load;

`ifdef STREAM_MUX_LOCK_EN
    assign w_pkt_end = in_last[w_gnt_idx];
`else
    assign w_pkt_end = 1'b1;
`endif

    assign w_nxt_ptr = (int'(w_gnt_idx) == NUM_CH - 1) ? '0 : w_gnt_idx + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_ch_data[w_gnt_idx];
                r_out_ch    <= w_gnt_idx;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Pointer moves only in round-robin mode and only at packet end.
            if (w_accept && (mode == MODE_RR) && w_pkt_end) begin
                r_rr_ptr <= w_nxt_ptr;
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_ch  <= '0;
            r_out_last <= 1'b0;
        end else if (w_accept) begin
            r_lock     <= ~w_pkt_end;
            r_lock_ch  <= w_gnt_idx;
            r_out_last <= w_pkt_end;
        end
    end

    assign out_last = r_out_last;
`endif

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_nto1
// Directed bench for stream_mux_nto1 (NUM_CH=4, DATA_W=8). Inputs change one
// time unit after a rising edge; outputs are observed at the same offset.
// Lock scenarios are compiled in when STREAM_MUX_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_stream_mux_nto1;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     mode;
    logic [CH_W-1:0]          sel;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_ready;
`ifdef STREAM_MUX_LOCK_EN
    logic [NUM_CH-1:0]        in_last;
    logic                     out_last;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] ch_byte [NUM_CH] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    always #5 clk = ~clk;

    stream_mux_nto1 #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = 32'hDDCCBBAA;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        in_last   = 4'b0000;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'h00) $display("FAIL rst_out_data got %h want 00", out_data); else n_pass++;
        n_total++; if (out_ch !== 2'd0) $display("FAIL rst_out_ch got %0d want 0", out_ch); else n_pass++;
        n_total++; if (in_ready !== 4'b0000) $display("FAIL rst_in_ready got %b want 0000", in_ready); else n_pass++;
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 4'b0001) $display("FAIL rel_in_ready got %b want 0001", in_ready); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rel_no_accept got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_fixed();
        logic [NUM_CH-1:0] exp_rdy;
        mode     = 1'b0;
        in_valid = 4'b1111;
        for (int s = 0; s < NUM_CH; s++) begin
            sel = CH_W'(s);
            #1;
            exp_rdy = 4'b0001 << s;
            n_total++; if (in_ready !== exp_rdy) $display("FAIL fix_in_ready sel=%0d got %b want %b", s, in_ready, exp_rdy); else n_pass++;
            step();
            n_total++; if (out_data !== ch_byte[s]) $display("FAIL fix_data sel=%0d got %h want %h", s, out_data, ch_byte[s]); else n_pass++;
            n_total++; if (out_ch !== CH_W'(s)) $display("FAIL fix_ch got %0d want %0d", out_ch, s); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL fix_valid sel=%0d got %b want 1", s, out_valid); else n_pass++;
        end
        // Ready in fixed mode ignores valid; with no valid the register drains.
        in_valid = 4'b0000;
        sel      = 2'd2;
        #1;
        n_total++; if (in_ready !== 4'b0100) $display("FAIL fix_rdy_novalid got %b want 0100", in_ready); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'hDD) $display("FAIL drain_hold_data got %h want DD", out_data); else n_pass++;
        n_total++; if (out_ch !== 2'd3) $display("FAIL drain_hold_ch got %0d want 3", out_ch); else n_pass++;
    endtask

    task automatic test_rr_all();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        mode     = 1'b1;
        in_valid = 4'b1111;
        #1;
        n_total++; if (in_ready !== 4'b0001) $display("FAIL rr_first_ready got %b want 0001", in_ready); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step();
            n_total++; if (out_ch !== CH_W'(exp_seq[i])) $display("FAIL rr_all_ch beat=%0d got %0d want %0d", i, out_ch, exp_seq[i]); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL rr_all_bubble beat=%0d got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (out_data !== ch_byte[exp_seq[i]]) $display("FAIL rr_all_data beat=%0d got %h want %h", i, out_data, ch_byte[exp_seq[i]]); else n_pass++;
        end
    endtask

    task automatic test_rr_pair();
        // Pointer sits at 2 here, so ch3 is found first.
        int exp_seq [4] = '{3, 1, 3, 1};
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if (out_ch !== CH_W'(exp_seq[i])) $display("FAIL rr_pair_ch beat=%0d got %0d want %0d", i, out_ch, exp_seq[i]); else n_pass++;
        end
    endtask

    task automatic test_rr_wrap();
        in_valid = 4'b1000;
        #1;
        n_total++; if (in_ready !== 4'b1000) $display("FAIL wrap_ready3 got %b want 1000", in_ready); else n_pass++;
        step();
        n_total++; if (out_ch !== 2'd3) $display("FAIL wrap_ch3 got %0d want 3", out_ch); else n_pass++;
        in_valid = 4'b1111;
        #1;
        n_total++; if (in_ready !== 4'b0001) $display("FAIL wrap_ptr0_ready got %b want 0001", in_ready); else n_pass++;
        step();
        n_total++; if (out_ch !== 2'd0) $display("FAIL wrap_ch0 got %0d want 0", out_ch); else n_pass++;
        n_total++; if (out_data !== 8'hAA) $display("FAIL wrap_data got %h want AA", out_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        n_total++; if (in_ready !== 4'b0000) $display("FAIL bp_ready0 got %b want 0000", in_ready); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (in_ready !== 4'b0000) $display("FAIL bp_ready cyc=%0d got %b want 0000", i, in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got %b want 1", i, out_valid); else n_pass++;
            n_total++; if (out_ch !== 2'd0) $display("FAIL bp_ch cyc=%0d got %0d want 0", i, out_ch); else n_pass++;
            n_total++; if (out_data !== 8'hAA) $display("FAIL bp_data cyc=%0d got %h want AA", i, out_data); else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++; if (in_ready !== 4'b0010) $display("FAIL bp_resume_ready got %b want 0010", in_ready); else n_pass++;
        step();
        n_total++; if (out_ch !== 2'd1) $display("FAIL bp_resume_ch got %0d want 1", out_ch); else n_pass++;
        n_total++; if (out_data !== 8'hBB) $display("FAIL bp_resume_data got %h want BB", out_data); else n_pass++;
    endtask

    task automatic test_mode_freeze();
        // Pointer is 2; a fixed-mode beat must not move it.
        mode = 1'b0;
        sel  = 2'd0;
        step();
        n_total++; if (out_ch !== 2'd0) $display("FAIL freeze_fixed_ch got %0d want 0", out_ch); else n_pass++;
        mode = 1'b1;
        #1;
        n_total++; if (in_ready !== 4'b0100) $display("FAIL freeze_rr_ready got %b want 0100", in_ready); else n_pass++;
        step();
        n_total++; if (out_ch !== 2'd2) $display("FAIL freeze_rr_ch got %0d want 2", out_ch); else n_pass++;
        in_valid = 4'b0000;
        step();
    endtask

`ifdef STREAM_MUX_LOCK_EN
    task automatic apply_reset();
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lock();
        apply_reset();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        step();
        n_total++; if (out_ch !== 2'd2) $display("FAIL lock_b1_ch got %0d want 2", out_ch); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL lock_b1_last got %b want 0", out_last); else n_pass++;
        in_valid = 4'b0101;
        #1;
        n_total++; if (in_ready !== 4'b0100) $display("FAIL lock_hold_ready got %b want 0100", in_ready); else n_pass++;
        step();
        n_total++; if (out_ch !== 2'd2) $display("FAIL lock_b2_ch got %0d want 2", out_ch); else n_pass++;
        in_last = 4'b0100;
        step();
        n_total++; if (out_ch !== 2'd2) $display("FAIL lock_b3_ch got %0d want 2", out_ch); else n_pass++;
        n_total++; if (out_last !== 1'b1) $display("FAIL lock_b3_last got %b want 1", out_last); else n_pass++;
        in_last = 4'b0000;
        step();
        n_total++; if (out_ch !== 2'd0) $display("FAIL lock_after_ch got %0d want 0", out_ch); else n_pass++;
    endtask

    task automatic test_lock_reset();
        apply_reset();
        mode     = 1'b1;
        in_valid = 4'b0100;
        step();
        n_total++; if (out_ch !== 2'd2) $display("FAIL lrst_lock_ch got %0d want 2", out_ch); else n_pass++;
        in_valid = 4'b0101;
        rst_n    = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL lrst_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 4'b0000) $display("FAIL lrst_ready got %b want 0000", in_ready); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL lrst_last got %b want 0", out_last); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 4'b0001) $display("FAIL lrst_unlock_ready got %b want 0001", in_ready); else n_pass++;
        step();
        n_total++; if (out_ch !== 2'd0) $display("FAIL lrst_next_ch got %0d want 0", out_ch); else n_pass++;
        n_total++; if (out_data !== 8'hAA) $display("FAIL lrst_next_data got %h want AA", out_data); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_pair();
        test_rr_wrap();
        test_backpressure();
        test_mode_freeze();
`ifdef STREAM_MUX_LOCK_EN
        test_lock();
        test_lock_reset();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
